// File: rtl/serial_addsub_seq_if.sv
// serial_addsub_seq_if: request/response bundle for the bit-serial add/sub
// sequencer.
//   master : start, sub, a, b                      -> sequencer
//   slave  : in_ready, busy, done, result, cout, ovf -> requester
interface serial_addsub_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  in_ready, busy, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output in_ready, busy, done, result, cout, ovf
  );
endinterface

// File: rtl/serial_addsub_seq.sv
// serial_addsub_seq: bit-serial add/subtract sequencer. One full-adder stage
// is reused for every bit position, LSB first, one bit per clock.
//   clk, rst_n   : clock, async active-low reset
//   bus.start    : request, taken when in_ready=1 (captures sub/a/b)
//   bus.in_ready : high in IDLE and DONE
//   bus.busy     : high in RUN
//   bus.done     : one-cycle pulse, result/cout/ovf just updated
//   bus.result   : last sum/difference, held until the next done
//   bus.cout     : carry out of MSB (sub: 1 = no borrow)
//   bus.ovf      : signed overflow of the last operation
module serial_addsub_seq #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_addsub_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nxt;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] cnt;
  logic             carry, cout_q, ovf_q;
  logic             s, c, c_msb_in, last, accept;
  logic             in_ready, busy, done;

  // shared full-adder stage
  assign s        = a_sr[0] ^ b_sr[0] ^ carry;
  assign c        = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign sum_nxt  = {s, sum_sr[WIDTH-1:1]};
  assign last     = (cnt == CNT_W'(WIDTH - 1));
  // carry into the MSB position is the live carry on the last bit edge
  assign c_msb_in = carry;
  assign accept   = in_ready & bus.start;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state only, no combinational path from start
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      RUN:     busy     = 1'b1;
      DONE:    begin in_ready = 1'b1; done = 1'b1; end
      default: in_ready = 1'b1;
    endcase
  end

  // datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      sum_sr   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      // subtraction as a + ~b + 1: invert b, seed carry with 1
      a_sr  <= bus.a;
      b_sr  <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub;
      cnt   <= '0;
    end else if (busy) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= sum_nxt;
      carry  <= c;
      cnt    <= cnt + 1'b1;
      if (last) begin
        result_q <= sum_nxt;
        cout_q   <= c;
        ovf_q    <= c_msb_in ^ c;
      end
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_serial_addsub_seq.sv
module tb_serial_addsub_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   ops_done = 0;
  int   last_done_cyc = 0;

  serial_addsub_seq_if #(.WIDTH(W)) bus();

  serial_addsub_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // reference: plain integer arithmetic on the operands
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                                output logic [W-1:0] r, output logic co, output logic ov);
    int ua, ub, sa, sb, t;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    if (sv) begin
      r  = W'(ua - ub);
      co = (ua >= ub);
      t  = sa - sb;
    end else begin
      r  = W'(ua + ub);
      co = ((ua + ub) > 255);
      t  = sa + sb;
    end
    ov = (t > 127) || (t < -128);
  endfunction

  // Issues one op and waits for done. Call at a time away from posedge.
  // noise: scramble a/b/sub and pulse start while busy.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                       input bit noise, input int exp_gap);
    logic [W-1:0] er, prev;
    logic         eco, eov;
    int           n, edges, busy_cnt;
    bit           stable;
    model(av, bv, sv, er, eco, eov);
    n = 0;
    while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
    chk("ready_wait", 32'(n < 100), 1);
    prev = bus.result;
    bus.start = 1'b1; bus.a = av; bus.b = bv; bus.sub = sv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy_cnt = int'(bus.busy);
    stable = 1'b1;
    edges = 0;
    while (!bus.done && edges < 40) begin
      if (noise) begin
        bus.a = W'($urandom); bus.b = W'($urandom); bus.sub = 1'($urandom);
        bus.start = 1'($urandom);
      end
      @(posedge clk); #1;
      edges++;
      if (!bus.done) begin
        busy_cnt += int'(bus.busy);
        if (bus.result !== prev) stable = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk("latency", 32'(edges), 32'(W));
    chk("busy_cycles", 32'(busy_cnt), 32'(W));
    chk("busy_in_done", 32'(bus.busy), 0);
    chk("result_hold", 32'(stable), 1);
    chk("result", 32'(bus.result), 32'(er));
    chk("cout", 32'(bus.cout), 32'(eco));
    chk("ovf", 32'(bus.ovf), 32'(eov));
    if (exp_gap > 0) chk("done_gap", 32'(cyc - last_done_cyc), 32'(exp_gap));
    last_done_cyc = cyc;
    ops_done++;
  endtask

  initial begin
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    #12;
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_flags", {29'd0, bus.cout, bus.ovf, bus.done}, 0);
    chk("rst_ready", {30'd0, bus.in_ready, bus.busy}, 32'b10);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // directed
    do_op(8'h35, 8'h1A, 1'b0, 1'b0, 0);
    chk("dir_4f", 32'(bus.result), 32'h4F);
    @(negedge clk);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    @(negedge clk);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
    chk("dir_ovf", {23'd0, bus.ovf, bus.result}, {23'd0, 1'b1, 8'h80});
    @(negedge clk);
    do_op(8'h10, 8'h20, 1'b1, 1'b0, 0);
    @(negedge clk);
    do_op(8'h80, 8'h01, 1'b1, 1'b0, 0);
    chk("dir_sub", {22'd0, bus.cout, bus.ovf, bus.result}, {22'd0, 2'b11, 8'h7F});
    @(negedge clk);
    // operands and start wiggle during RUN
    do_op(8'h01, 8'h01, 1'b0, 1'b1, 0);
    // back-to-back: issued straight from the DONE cycle
    do_op(8'h03, 8'h04, 1'b0, 1'b0, 0);
    do_op(8'h10, 8'h01, 1'b1, 1'b0, W + 1);
    chk("b2b_res", 32'(bus.result), 32'h0F);
    @(negedge clk); @(negedge clk);
    chk("done_pulses", 32'(done_cnt), 32'(ops_done));

    // reset mid-RUN
    bus.start = 1'b1; bus.a = 8'h55; bus.b = 8'h0F; bus.sub = 1'b0;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {20'd0, bus.result, bus.cout, bus.ovf, bus.done, bus.busy}, 0);
    chk("mid_rst_ready", 32'(bus.in_ready), 1);
    repeat (12) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("mid_rst_nodone", 32'(done_cnt), 32'(ops_done));
    do_op(8'h22, 8'h11, 1'b0, 1'b0, 0);
    chk("post_rst", 32'(bus.result), 32'h33);

    // random, mix of idle gaps and back-to-back
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 0);
    end
    @(negedge clk); @(negedge clk);
    chk("done_total", 32'(done_cnt), 32'(ops_done));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_addsub_seq.md
Name: serial_addsub_seq

Overview:
Bit-serial add/subtract sequencer. It time-shares one 1-bit full-adder stage across all WIDTH bit positions, LSB first, one bit per clock. It owns operand capture, carry storage, bit counting and the start/done handshake. Upstream control logic uses it where area matters more than latency.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)
CNT_W, $clog2(WIDTH)+1, bit-counter width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when in_ready=1
sub  in  1  0 = a+b, 1 = a-b; captured with start
a  in  WIDTH  operand A; captured with start
b  in  WIDTH  operand B; captured with start
in_ready  out  1  high in IDLE and DONE; start accepted on this edge
busy  out  1  high in RUN
done  out  1  one-cycle pulse: result, cout and ovf are valid and updated
result  out  WIDTH  last completed sum/difference, held until the next done
cout  out  1  carry out of the MSB (for sub: 1 = no borrow)
ovf  out  1  two's-complement signed overflow of the last operation

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; bit counter, carry, operand and sum shift registers = 0.
  - result=0, cout=0, ovf=0, done=0, busy=0, in_ready=1.
  - Reset during RUN abandons the operation; no done is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> RUN.
  - RUN: count reaches WIDTH-1 -> DONE.
  - DONE: start=1 -> RUN (back-to-back operation); otherwise -> IDLE.
- Accept edge (in_ready=1 and start=1):
  - Capture a into the A shift register.
  - Capture b into the B shift register, with b inverted when sub=1.
  - carry <= sub; count <= 0.
- RUN, each edge:
  - s = A[0]^B[0]^carry; c = majority(A[0], B[0], carry).
  - Shift A and B right by one. Shift s into the sum register from the MSB end.
  - carry <= c; count <= count+1.
  - On the count=WIDTH-1 edge, also save the incoming carry as c_msb_in.
- Transition edge into DONE:
  - result <= final sum register contents, including the bit produced on this edge.
  - cout <= c; ovf <= c_msb_in ^ c.
  - done=1 for exactly the DONE cycle.
- Latency: done is high during the cycle that begins WIDTH clock edges after the accept edge. Throughput is one operation per WIDTH+1 clocks when start is held high.
- start in RUN is ignored. Operands are not re-sampled, and a/b/sub may change freely during RUN.
- result, cout and ovf change only on the DONE-entry edge and are stable at all other times.
- busy and in_ready are mutually exclusive and decoded from state, so there is no combinational path from start.
- Arithmetic is modulo 2^WIDTH. Subtraction is a + ~b + 1.

Test Plan:
- WIDTH=8, a=0x35, b=0x1A, sub=0 -> done exactly 8 edges after the accept edge; result=0x4F, cout=0, ovf=0; busy high for 8 cycles.
- a=0xFF, b=0x01, sub=0 -> result=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01, sub=0 -> result=0x80, cout=0, ovf=1.
- a=0x10, b=0x20, sub=1 -> result=0xF0, cout=0, ovf=0. Then a=0x80, b=0x01, sub=1 -> result=0x7F, cout=1, ovf=1.
- Accept a=0x01/b=0x01; pulse start with a=0xAA during RUN and toggle a/b each cycle -> result=0x02, single done pulse, the extra start is ignored.
- start held high across two operations (0x03+0x04, then 0x10-0x01) -> done pulses 9 cycles apart; result 0x07, then 0x0F; busy drops to 0 only for each DONE cycle.
- Assert rst_n=0 mid-RUN after 3 bits -> all outputs 0 immediately, in_ready=1, no done. A new op (0x22+0x11) after release -> 0x33.
